// File: rtl/fifo_pkg.sv
// Shared constants, pause FSM encoding and a clog2 helper for the
// parametrised flow-control FIFO.
package fifo_pkg;

   localparam int DEF_DATA_SIZE = 8;
   localparam int DEF_DEPTH     = 8;
   localparam int DEF_ADDR_SIZE = 3;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } pause_st_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_SIZE storage: synchronous write port, asynchronous read
// port. No reset; contents are only meaningful where the top says so.
module fifo_mem_dp
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_SIZE-1:0] waddr,
   input  logic [DATA_SIZE-1:0] wdata,
   input  logic [ADDR_SIZE-1:0] raddr,
   output logic [DATA_SIZE-1:0] rdata
);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_param_fc.sv
// Parametrised synchronous FIFO with programmable thresholds, hysteretic
// pause and sticky errors. Define FIFO_FWFT_EN for first-word-fall-through.
module fifo_param_fc
   import fifo_pkg::*;
#(
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ADDR_SIZE = clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write,
   input  logic [DATA_SIZE-1:0] data_in_push,
   input  logic                 read,
   input  logic [ADDR_SIZE:0]   af_thresh,
   input  logic [ADDR_SIZE:0]   ae_thresh,
   output logic [DATA_SIZE-1:0] data_out_pop,
   output logic                 valid_out,
   output logic                 fifo_empty,
   output logic                 fifo_full,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 fifo_pause,
   output logic                 fifo_error,
   output logic                 overflow_err,
   output logic                 underflow_err,
   output logic [ADDR_SIZE:0]   count
);

   localparam logic [ADDR_SIZE:0] FULL_CNT = (ADDR_SIZE+1)'(DEPTH);

   logic [ADDR_SIZE-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_SIZE:0]   count_q, count_d;
   logic                 ovf_q, udf_q;
   pause_st_e            st_q, st_d;
   logic                 push, pop;
   logic [DATA_SIZE-1:0] head;

   assign fifo_empty   = (count_q == '0);
   assign fifo_full    = (count_q == FULL_CNT);
   assign almost_full  = (count_q >= af_thresh);
   assign almost_empty = (count_q <= ae_thresh);
   assign count        = count_q;

   // A full FIFO still takes a push when a pop frees the slot this cycle.
   assign push = write && (!fifo_full || read);
   assign pop  = read && !fifo_empty;

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         ST_RUN:   if (count_d >= af_thresh) st_d = ST_PAUSE;
         ST_PAUSE: if (count_d <= ae_thresh) st_d = ST_RUN;
         default:  st_d = ST_RUN;
      endcase
   end

   // Without a usable hysteresis window, fall back to almost_full.
   assign fifo_pause = (ae_thresh >= af_thresh) ? almost_full
                                                : (st_q == ST_PAUSE);

   assign overflow_err  = ovf_q;
   assign underflow_err = udf_q;
   assign fifo_error    = ovf_q | udf_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         st_q     <= ST_RUN;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         st_q    <= st_d;
         if (write && fifo_full && !read) ovf_q <= 1'b1;
         if (read && fifo_empty)          udf_q <= 1'b1;
      end
   end

   fifo_mem_dp #(
      .DATA_SIZE (DATA_SIZE),
      .DEPTH     (DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (data_in_push),
      .raddr (rd_ptr_q),
      .rdata (head)
   );

`ifdef FIFO_FWFT_EN
   assign data_out_pop = fifo_empty ? '0 : head;
   assign valid_out    = !fifo_empty;
`else
   logic [DATA_SIZE-1:0] dout_q;
   logic                 vld_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         dout_q <= '0;
         vld_q  <= 1'b0;
      end else begin
         vld_q <= pop;
         if (pop) dout_q <= head;
      end
   end

   assign data_out_pop = dout_q;
   assign valid_out    = vld_q;
`endif

endmodule
